// File: rtl/mipsfpga_system_if.sv
// Core-side AHB-Lite and core control/debug bundle for mipsfpga_system.
// master: the microAptiv core (drives address/control/write data and EJ_TDO).
// slave : the system fabric (returns read data/ready/response, forwards
//         reset and EJTAG pins to the core).
interface mipsfpga_system_if;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic        reset_n;
    logic        cold_reset_n;
    logic        ej_trst_n;
    logic        ej_tdi;
    logic        ej_tdo;
    logic        ej_tms;
    logic        ej_tck;
    logic        ej_dint;

    modport master (
        output haddr, hwdata, hwrite, htrans, hsize, ej_tdo,
        input  hrdata, hready, hresp, reset_n, cold_reset_n,
               ej_trst_n, ej_tdi, ej_tms, ej_tck, ej_dint
    );

    modport slave (
        input  haddr, hwdata, hwrite, htrans, hsize, ej_tdo,
        output hrdata, hready, hresp, reset_n, cold_reset_n,
               ej_trst_n, ej_tdi, ej_tms, ej_tck, ej_dint
    );
endinterface

// File: rtl/mipsfpga_system.sv
// MIPSfpga system fabric: AHB-Lite decoder, reset (boot) RAM, program RAM and
// board GPIO. The core attaches through the `core` interface (slave modport).
// Ports: SI_ClkIn/SI_Reset_N clock and async active-low reset; HADDR/HRDATA/
// HWDATA/HWRITE bus observation; EJ_*/SI_ColdReset_N forwarded to the core;
// IO_Switch/IO_PB board inputs; IO_LEDR/IO_LEDG board LEDs.
// Physical decode on HADDR[28:0]:
//   0x1FC0_0000..0x1FFF_FFFF reset RAM, 0x1F80_0000..0x1F80_000F GPIO,
//   0x0000_0000..0x000F_FFFF program RAM, everything else unmapped.
module mipsfpga_system #(
    parameter int unsigned H_RAM_RESET_ADDR_WIDTH = 8,
    parameter int unsigned H_RAM_ADDR_WIDTH       = 8
) (
    input  logic        SI_ClkIn,
    input  logic        SI_Reset_N,
    output logic [31:0] HADDR,
    output logic [31:0] HRDATA,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic        EJ_TRST_N_probe,
    input  logic        EJ_TDI,
    output logic        EJ_TDO,
    input  logic        EJ_TMS,
    input  logic        EJ_TCK,
    input  logic        SI_ColdReset_N,
    input  logic        EJ_DINT,
    input  logic [17:0] IO_Switch,
    input  logic [4:0]  IO_PB,
    output logic [17:0] IO_LEDR,
    output logic [8:0]  IO_LEDG,
    mipsfpga_system_if.slave core
);
    localparam int unsigned RA    = H_RAM_RESET_ADDR_WIDTH;
    localparam int unsigned PA    = H_RAM_ADDR_WIDTH;
    localparam int unsigned IDX_W = (RA > PA) ? RA : PA;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_RST, SEL_PRG, SEL_LEDR, SEL_LEDG, SEL_SW, SEL_PB
    } sel_e;

    // Pass-through between board pins and the core.
    assign core.reset_n      = SI_Reset_N;
    assign core.cold_reset_n = SI_ColdReset_N;
    assign core.ej_trst_n    = EJ_TRST_N_probe;
    assign core.ej_tdi       = EJ_TDI;
    assign core.ej_tms       = EJ_TMS;
    assign core.ej_tck       = EJ_TCK;
    assign core.ej_dint      = EJ_DINT;
    assign EJ_TDO            = core.ej_tdo;
    assign core.hready       = 1'b1;
    assign core.hresp        = 2'b00;
    assign HADDR             = core.haddr;
    assign HWDATA            = core.hwdata;
    assign HWRITE            = core.hwrite;

    sel_e             sel_c, sel_d, sel_q;
    logic [3:0]       be_c, be_d, be_q;
    logic             valid_d, valid_q, write_d, write_q;
    logic [IDX_W-1:0] widx_d, widx_q;
    logic [17:0]      ledr_d, ledr_q, sw_meta_q, sw_sync_q;
    logic [8:0]       ledg_d, ledg_q;
    logic [4:0]       pb_meta_q, pb_sync_q;
    logic [31:0]      rst_rdata_d, rst_rdata_q, prg_rdata_d, prg_rdata_q;
    logic [31:0]      hrdata_c;
    logic [31:0]      rst_mem [1 << RA];
    logic [31:0]      prg_mem [1 << PA];
    logic [RA-1:0]    rst_ridx, rst_widx;
    logic [PA-1:0]    prg_ridx, prg_widx;
    logic             rst_we, prg_we;

    // Address decode and little-endian byte-lane generation.
    always_comb begin
        sel_c = SEL_NONE;
        if (core.haddr[28:22] == 7'h7F) begin
            sel_c = SEL_RST;
        end else if (core.haddr[28:4] == 25'h1F8_0000) begin
            case (core.haddr[3:2])
                2'd0:    sel_c = SEL_LEDR;
                2'd1:    sel_c = SEL_LEDG;
                2'd2:    sel_c = SEL_SW;
                default: sel_c = SEL_PB;
            endcase
        end else if (core.haddr[28:20] == 9'h000) begin
            sel_c = SEL_PRG;
        end
        case (core.hsize[1:0])
            2'd0:    be_c = 4'b0001 << core.haddr[1:0];
            2'd1:    be_c = core.haddr[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
    end

    // Phase registers and GPIO next state.
    always_comb begin
        valid_d = core.htrans[1];
        sel_d   = sel_q;
        write_d = write_q;
        be_d    = be_q;
        widx_d  = widx_q;
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        if (core.htrans[1]) begin
            sel_d   = sel_c;
            write_d = core.hwrite;
            be_d    = be_c;
            widx_d  = core.haddr[IDX_W+1:2];
        end
        if (valid_q && write_q && sel_q == SEL_LEDR) ledr_d = core.hwdata[17:0];
        if (valid_q && write_q && sel_q == SEL_LEDG) ledg_d = core.hwdata[8:0];
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            valid_q   <= 1'b0;
            sel_q     <= SEL_NONE;
            write_q   <= 1'b0;
            be_q      <= 4'b0;
            widx_q    <= '0;
            ledr_q    <= 18'b0;
            ledg_q    <= 9'b0;
            sw_meta_q <= 18'b0;
            sw_sync_q <= 18'b0;
            pb_meta_q <= 5'b0;
            pb_sync_q <= 5'b0;
        end else begin
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            write_q   <= write_d;
            be_q      <= be_d;
            widx_q    <= widx_d;
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            sw_meta_q <= IO_Switch;
            sw_sync_q <= sw_meta_q;
            pb_meta_q <= IO_PB;
            pb_sync_q <= pb_meta_q;
        end
    end

    assign IO_LEDR = ledr_q;
    assign IO_LEDG = ledg_q;

    // RAM ports: read indexed in the address phase, write in the data phase.
    assign rst_ridx = core.haddr[RA+1:2];
    assign prg_ridx = core.haddr[PA+1:2];
    assign rst_widx = widx_q[RA-1:0];
    assign prg_widx = widx_q[PA-1:0];
    assign rst_we   = valid_q && write_q && sel_q == SEL_RST;
    assign prg_we   = valid_q && write_q && sel_q == SEL_PRG;

    // Write-to-read bypass so a read right behind a write sees the new bytes.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rst_rdata_d[8*i +: 8] = (rst_we && be_q[i] && rst_widx == rst_ridx)
                                    ? core.hwdata[8*i +: 8] : rst_mem[rst_ridx][8*i +: 8];
            prg_rdata_d[8*i +: 8] = (prg_we && be_q[i] && prg_widx == prg_ridx)
                                    ? core.hwdata[8*i +: 8] : prg_mem[prg_ridx][8*i +: 8];
        end
    end

    // RAM arrays and read registers; contents are deliberately not reset.
    always_ff @(posedge SI_ClkIn) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_we && be_q[i]) rst_mem[rst_widx][8*i +: 8] <= core.hwdata[8*i +: 8];
            if (prg_we && be_q[i]) prg_mem[prg_widx][8*i +: 8] <= core.hwdata[8*i +: 8];
        end
        rst_rdata_q <= rst_rdata_d;
        prg_rdata_q <= prg_rdata_d;
    end

    // Data-phase read mux; unmapped and non-read cycles return zero.
    always_comb begin
        hrdata_c = 32'b0;
        if (valid_q && !write_q) begin
            case (sel_q)
                SEL_RST:  hrdata_c = rst_rdata_q;
                SEL_PRG:  hrdata_c = prg_rdata_q;
                SEL_LEDR: hrdata_c = {14'b0, ledr_q};
                SEL_LEDG: hrdata_c = {23'b0, ledg_q};
                SEL_SW:   hrdata_c = {14'b0, sw_sync_q};
                SEL_PB:   hrdata_c = {27'b0, pb_sync_q};
                default:  hrdata_c = 32'b0;
            endcase
        end
    end

    assign core.hrdata = hrdata_c;
    assign HRDATA      = hrdata_c;

    logic unused_bits;
    assign unused_bits = ^{core.haddr[31:29], core.hsize[2], core.htrans[0]};
endmodule

// File: tb/tb_mipsfpga_system.sv
// Bench for mipsfpga_system: the bench plays the core on the AHB-Lite bus,
// issues pipelined transfers and compares against a byte-level memory model.
module tb_mipsfpga_system;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr_o, hrdata_o, hwdata_o;
    logic        hwrite_o, ej_tdo_o;
    logic        ej_tdi = 1'b0;
    logic [17:0] sw = 18'h0;
    logic [4:0]  pb = 5'h0;
    logic [17:0] ledr_o;
    logic [8:0]  ledg_o;

    int total = 0;
    int bad   = 0;

    mipsfpga_system_if bus ();

    mipsfpga_system dut (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n),
        .HADDR(haddr_o), .HRDATA(hrdata_o), .HWDATA(hwdata_o), .HWRITE(hwrite_o),
        .EJ_TRST_N_probe(1'b1), .EJ_TDI(ej_tdi), .EJ_TDO(ej_tdo_o),
        .EJ_TMS(1'b0), .EJ_TCK(1'b0), .SI_ColdReset_N(1'b1), .EJ_DINT(1'b0),
        .IO_Switch(sw), .IO_PB(pb), .IO_LEDR(ledr_o), .IO_LEDG(ledg_o),
        .core(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] d;
    } txn_t;

    // Reference state
    logic [31:0] m_rst [256];
    logic [31:0] m_prg [256];
    logic [17:0] m_ledr = 18'h0;
    logic [8:0]  m_ledg = 9'h0;
    txn_t        prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic v, input logic [31:0] a, input logic w,
                                input logic [2:0] sz, input logic [31:0] d);
        mk = '{v: v, a: a, w: w, sz: sz, d: d};
    endfunction

    // 0 unmapped, 1 reset RAM, 2 program RAM, 3 GPIO
    function automatic int region(input logic [31:0] a);
        logic [28:0] p;
        p = a[28:0];
        if (p >= 29'h1FC0_0000) return 1;
        if (p >= 29'h1F80_0000 && p < 29'h1F80_0010) return 3;
        if (p < 29'h0010_0000) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
        if (sz == 3'd0) return 4'b0001 << a[1:0];
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] ln);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (ln[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Retire one transfer against the model: check reads, absorb writes.
    task automatic apply(input txn_t t);
        int          rg;
        int          idx;
        logic [31:0] exp;
        rg  = region(t.a);
        idx = int'(t.a[9:2]);
        if (t.w) begin
            case (rg)
                1: m_rst[idx] = merge(m_rst[idx], t.d, lanes(t.a, t.sz));
                2: m_prg[idx] = merge(m_prg[idx], t.d, lanes(t.a, t.sz));
                3: if (t.a[3:2] == 2'd0) m_ledr = t.d[17:0];
                   else if (t.a[3:2] == 2'd1) m_ledg = t.d[8:0];
                default: ;
            endcase
        end else begin
            case (rg)
                1: exp = m_rst[idx];
                2: exp = m_prg[idx];
                3: case (t.a[3:2])
                       2'd0: exp = {14'b0, m_ledr};
                       2'd1: exp = {23'b0, m_ledg};
                       2'd2: exp = {14'b0, sw};
                       default: exp = {27'b0, pb};
                   endcase
                default: exp = 32'h0;
            endcase
            check("hrdata", hrdata_o, exp);
        end
    endtask

    // One bus cycle: address phase of cur, data phase of prev.
    task automatic cycle(input txn_t cur);
        bus.htrans = cur.v ? ($urandom_range(0, 1) ? 2'd3 : 2'd2) : 2'd0;
        bus.haddr  = cur.a;
        bus.hwrite = cur.w;
        bus.hsize  = cur.sz;
        bus.hwdata = (prev.v && prev.w) ? prev.d : $urandom();
        @(negedge clk);
        check("haddr", haddr_o, cur.a);
        check("ledr", {14'b0, ledr_o}, {14'b0, m_ledr});
        check("ledg", {23'b0, ledg_o}, {23'b0, m_ledg});
        if (prev.v) apply(prev);
        @(posedge clk);
        #1;
        prev = cur;
    endtask

    function automatic txn_t rand_txn();
        logic [31:0] a;
        logic [2:0]  sz;
        case ($urandom_range(0, 4))
            0: a = 32'h8000_0000 | 32'($urandom_range(0, 4095));
            1: a = 32'hA000_0000 | 32'($urandom_range(0, 32'hF_FFFF));
            2: a = 32'hBFC0_0000 | 32'($urandom_range(0, 8191));
            3: a = 32'hBF80_0000 | (32'($urandom_range(0, 4)) << 2);
            default: a = 32'h8800_0000 | 32'($urandom_range(0, 32'hFFFF));
        endcase
        sz = 3'($urandom_range(0, 2));
        a  = a & ~((32'd1 << sz) - 32'd1);
        return mk($urandom_range(0, 4) != 0, a, 1'($urandom_range(0, 1)), sz, $urandom());
    endfunction

    initial begin
        prev       = '0;
        bus.htrans = 2'd0;
        bus.haddr  = 32'h0;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd2;
        bus.hwdata = 32'h0;
        bus.ej_tdo = 1'b0;

        // Reset held low
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("rst_ledr", {14'b0, ledr_o}, 32'h0);
        check("rst_ledg", {23'b0, ledg_o}, 32'h0);
        check("rst_hwrite", {31'b0, hwrite_o}, 32'h0);
        check("rst_hrdata", hrdata_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // EJTAG and bus pass-through
        ej_tdi = 1'b1; bus.ej_tdo = 1'b1; #1;
        check("ej_tdi", {31'b0, bus.ej_tdi}, 32'h1);
        check("ej_tdo", {31'b0, ej_tdo_o}, 32'h1);
        check("hready", {31'b0, bus.hready}, 32'h1);

        // Fill both RAMs so every later read has a defined value
        for (int i = 0; i < 256; i++) cycle(mk(1, 32'hBFC0_0000 + 32'(i * 4), 1, 3'd2, $urandom()));
        for (int i = 0; i < 256; i++) cycle(mk(1, 32'h8000_0000 + 32'(i * 4), 1, 3'd2, $urandom()));

        // LEDR write; LEDG untouched
        cycle(mk(1, 32'hBF80_0000, 1, 3'd2, 32'h0001_2345));
        cycle(mk(0, 32'h0, 0, 3'd2, 32'h0));
        cycle(mk(0, 32'h0, 0, 3'd2, 32'h0));
        check("t2_ledr", {14'b0, ledr_o}, 32'h0001_2345);
        check("t2_ledg", {23'b0, ledg_o}, 32'h0);

        // Switch read through the synchronizer
        sw = 18'h2A5A5;
        repeat (3) cycle(mk(0, 32'h0, 0, 3'd2, 32'h0));
        cycle(mk(1, 32'hBF80_0008, 0, 3'd2, 32'h0));
        bus.htrans = 2'd0;
        @(negedge clk);
        check("t3_sw", hrdata_o, 32'h0002_A5A5);
        @(posedge clk); #1;
        prev = '0;

        // Word write then read back, back-to-back
        cycle(mk(1, 32'h8000_0010, 1, 3'd2, 32'hDEAD_BEEF));
        cycle(mk(1, 32'h8000_0010, 0, 3'd2, 32'h0));
        bus.htrans = 2'd0;
        @(negedge clk);
        check("t4_word", hrdata_o, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        prev = '0;

        // Byte write into a known word
        cycle(mk(1, 32'h8000_0020, 1, 3'd2, 32'h1122_3344));
        cycle(mk(1, 32'h8000_0021, 1, 3'd0, 32'hABAB_ABAB));
        cycle(mk(1, 32'h8000_0020, 0, 3'd2, 32'h0));
        bus.htrans = 2'd0;
        @(negedge clk);
        check("t5_byte", hrdata_o, 32'h1122_AB44);
        @(posedge clk); #1;
        prev = '0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 99) begin
                sw = 18'($urandom());
                pb = 5'($urandom());
                repeat (3) cycle(mk(0, $urandom(), 0, 3'd2, 32'h0));
            end
            cycle(rand_txn());
        end
        cycle(mk(0, 32'h0, 0, 3'd2, 32'h0));

        // Reset mid-transfer: LEDs clear asynchronously, pending write dropped
        cycle(mk(1, 32'hBF80_0000, 1, 3'd2, 32'h0003_FFFF));
        cycle(mk(1, 32'hBF80_0004, 1, 3'd2, 32'h0000_01AA));
        cycle(mk(1, 32'hBF80_0000, 1, 3'd2, 32'h0001_5555));
        bus.htrans = 2'd0;
        bus.hwrite = 1'b0;
        bus.hwdata = 32'h0001_5555;
        @(negedge clk);
        check("t6_pre_ledr", {14'b0, ledr_o}, 32'h0003_FFFF);
        check("t6_pre_ledg", {23'b0, ledg_o}, 32'h0000_01AA);
        rst_n = 1'b0;
        #1;
        check("t6_ledr", {14'b0, ledr_o}, 32'h0);
        check("t6_ledg", {23'b0, ledg_o}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        prev   = '0;
        m_ledr = 18'h0;
        m_ledg = 9'h0;
        repeat (2) cycle(mk(0, 32'h0, 0, 3'd2, 32'h0));
        check("t6_dropped", {14'b0, ledr_o}, 32'h0);

        // RAM contents survive reset
        cycle(mk(1, 32'h8000_0010, 0, 3'd2, 32'h0));
        cycle(mk(1, 32'hBFC0_0400, 0, 3'd2, 32'h0));
        cycle(mk(0, 32'h0, 0, 3'd2, 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
